// File: rtl/hwpe_stream_addressgen_nd.sv
// hwpe_stream_addressgen_nd
// N-dimensional streamer address generator with a valid/ready output.
// Dim 0 walks words inside a line. Dims 1..NB_DIMS-1 move the line start
// by their signed byte stride. A line whose start is not word aligned
// gets one extra beat. Its first and last beats carry partial byte strobes.

module hwpe_stream_addressgen_nd #(
    parameter int unsigned NB_DIMS = 3,
    parameter int unsigned STEP    = 4,
    parameter int unsigned CNT     = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [NB_DIMS*CNT-1:0]    len_m1_i,
    input  logic [NB_DIMS*ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0]         addr_o,
    output logic [STEP-1:0]           strb_o,
    output logic [NB_DIMS-1:0]        dim_last_o,
    output logic                      addr_valid_o,
    input  logic                      addr_ready_i,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int unsigned LOG = $clog2(STEP);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q;
    logic [CNT-1:0]      len0_q;
    logic [CNT:0]        word_q;

    logic                start_go;
    logic                beat_go;
    logic                run;
    logic [NB_DIMS-1:0]  at_len;
    logic [NB_DIMS-1:0]  dim_last;
    logic [ADDR_W-1:0]   off_v [NB_DIMS];
    logic [ADDR_W-1:0]   off_line;
    logic [ADDR_W-1:0]   line_start;
    logic [ADDR_W-1:0]   line_aligned;
    logic [ADDR_W-1:0]   addr_raw;
    logic [LOG-1:0]      line_ofs;
    logic                misaligned;
    logic [CNT:0]        beats_m1;
    logic                last_beat;
    logic [STEP-1:0]     first_mask;
    logic [STEP-1:0]     strb_raw;

    // test_mode_i and the dim 0 stride slice have no function here.
    logic unused_ok;
    assign unused_ok = ^{test_mode_i, stride_i[ADDR_W-1:0]};

    assign run          = (state_q == RUN);
    assign start_go     = (state_q == IDLE) & start_i & enable_i;
    assign addr_valid_o = run & enable_i;
    assign beat_go      = addr_valid_o & addr_ready_i;
    assign busy_o       = run;
    assign done_o       = (state_q == DONE);

    // Dim 0 has no counter of its own here, because the word counter covers it.
    assign at_len[0] = 1'b1;
    assign off_v[0]  = '0;

    // Outer dimensions each keep an iteration counter and a partial offset.
    // The partial offset always equals cnt*stride. It is built by adding the
    // stride, so no multiplier is needed.
    for (genvar d = 1; d < NB_DIMS; d++) begin : g_dim
        logic [CNT-1:0]    len_q;
        logic [CNT-1:0]    cnt_q;
        logic [ADDR_W-1:0] stride_q;
        logic [ADDR_W-1:0] off_q;

        assign at_len[d] = (cnt_q == len_q);
        assign off_v[d]  = off_q;

        // Advance this dimension only when every inner dimension closes on this beat.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                len_q    <= '0;
                cnt_q    <= '0;
                stride_q <= '0;
                off_q    <= '0;
            end else if (clear_i) begin
                len_q    <= '0;
                cnt_q    <= '0;
                stride_q <= '0;
                off_q    <= '0;
            end else if (enable_i) begin
                if (start_go) begin
                    len_q    <= len_m1_i[d*CNT +: CNT];
                    stride_q <= stride_i[d*ADDR_W +: ADDR_W];
                    cnt_q    <= '0;
                    off_q    <= '0;
                end else if (beat_go && dim_last[d-1]) begin
                    if (at_len[d]) begin
                        cnt_q <= '0;
                        off_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        off_q <= off_q + stride_q;
                    end
                end
            end
        end
    end

    // Line offset is the sum of the partial offsets of the outer dimensions.
    always_comb begin
        off_line = '0;
        for (int d = 0; d < NB_DIMS; d++) begin
            off_line = off_line + off_v[d];
        end
    end

    // Line geometry: start offset, number of beats and the current beat address.
    always_comb begin
        line_start   = base_q + off_line;
        line_ofs     = line_start[LOG-1:0];
        misaligned   = (line_ofs != '0);
        line_aligned = {line_start[ADDR_W-1:LOG], {LOG{1'b0}}};
        addr_raw     = line_aligned + (ADDR_W'(word_q) << LOG);
        beats_m1     = {1'b0, len0_q} + {{CNT{1'b0}}, misaligned};
        last_beat    = (word_q == beats_m1);
    end

    // Byte strobes: the head beat of a misaligned line skips the leading bytes.
    // The extra tail beat keeps only the bytes that the head beat skipped.
    always_comb begin
        first_mask = {STEP{1'b1}} << line_ofs;
        strb_raw   = {STEP{1'b1}};
        if (word_q == '0) begin
            strb_raw = first_mask;
        end else if (last_beat && misaligned) begin
            strb_raw = ~first_mask;
        end
    end

    // Each dimension closes when its own counter is at its limit and all inner dimensions close too.
    always_comb begin
        dim_last    = '0;
        dim_last[0] = last_beat & at_len[0];
        for (int d = 1; d < NB_DIMS; d++) begin
            dim_last[d] = dim_last[d-1] & at_len[d];
        end
    end

    // Outputs are forced to zero outside RUN, so IDLE and DONE look quiet.
    always_comb begin
        addr_o     = '0;
        strb_o     = '0;
        dim_last_o = '0;
        if (run) begin
            addr_o     = addr_raw;
            strb_o     = strb_raw;
            dim_last_o = dim_last;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_go) state_d = RUN;
            RUN:  if (beat_go && dim_last[NB_DIMS-1]) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, configuration snapshot and word counter. All of them freeze while enable_i is low.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            base_q  <= '0;
            len0_q  <= '0;
            word_q  <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            base_q  <= '0;
            len0_q  <= '0;
            word_q  <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
            if (start_go) begin
                base_q <= base_addr_i;
                len0_q <= len_m1_i[CNT-1:0];
                word_q <= '0;
            end else if (beat_go) begin
                word_q <= last_beat ? '0 : word_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hwpe_stream_addressgen_nd.sv
// tb_hwpe_stream_addressgen_nd
// Randomised and directed transfers are checked against a nested-loop
// reference model. The model computes every line start directly from the
// base address, the counters and the strides.

module tb_hwpe_stream_addressgen_nd;

    logic        clk;
    logic        rst_n;
    logic        test_mode;
    logic        enable;
    logic        clear;
    logic        start;
    logic [31:0] base_addr;
    logic [47:0] len_m1;
    logic [95:0] stride;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [2:0]  dim_last;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;

    int nChecks = 0;
    int nFails  = 0;

    hwpe_stream_addressgen_nd #(
        .NB_DIMS(3), .STEP(4), .CNT(16), .ADDR_W(32)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .test_mode_i(test_mode),
        .enable_i(enable),
        .clear_i(clear),
        .start_i(start),
        .base_addr_i(base_addr),
        .len_m1_i(len_m1),
        .stride_i(stride),
        .addr_o(addr),
        .strb_o(strb),
        .dim_last_o(dim_last),
        .addr_valid_o(valid),
        .addr_ready_i(ready),
        .busy_o(busy),
        .done_o(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Runs one transfer. It builds the expected beats, starts the generator and consumes
    // the beats with random ready/enable. It can stall for 5 cycles on one beat, or
    // clear after a given number of beats.
    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] l0, input logic [15:0] l1,
                                 input logic [15:0] l2, input logic [31:0] s1, input logic [31:0] s2,
                                 input int readyPct, input int enPct, input int stallBeat,
                                 input int clearAfter);
        logic [31:0] eAddr[$];
        logic [3:0]  eStrb[$];
        logic [2:0]  eLast[$];
        logic [31:0] ls;
        logic [3:0]  m;
        logic [1:0]  o;
        logic        d0, d1, d2;
        int          nb, total, pops, cyc, stall;

        for (int c2 = 0; c2 <= int'(l2); c2++) begin
            for (int c1 = 0; c1 <= int'(l1); c1++) begin
                ls = base + 32'(c1) * s1 + 32'(c2) * s2;
                o  = ls[1:0];
                nb = int'(l0) + 1 + ((o != 2'd0) ? 1 : 0);
                for (int b = 0; b < nb; b++) begin
                    eAddr.push_back((ls & 32'hFFFF_FFFC) + 32'(4 * b));
                    m = 4'hF;
                    m = m << o;
                    if (o == 2'd0)       eStrb.push_back(4'hF);
                    else if (b == 0)     eStrb.push_back(m);
                    else if (b == nb - 1) eStrb.push_back(~m);
                    else                 eStrb.push_back(4'hF);
                    d0 = (b == nb - 1);
                    d1 = d0 && (c1 == int'(l1));
                    d2 = d1 && (c2 == int'(l2));
                    eLast.push_back({d2, d1, d0});
                end
            end
        end
        total = eAddr.size();
        pops  = 0;
        cyc   = 0;
        stall = 0;

        @(negedge clk);
        base_addr = base;
        len_m1    = {l2, l1, l0};
        stride    = {s2, s1, $urandom()};
        enable    = 1'b1;
        ready     = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        base_addr = $urandom();
        len_m1    = {$urandom(), $urandom()};
        stride    = {$urandom(), $urandom(), $urandom()};
        #1;
        checkOutput("busyAfterStart", {63'd0, busy}, 64'd1);

        while (eAddr.size() > 0 && cyc < 4000) begin
            if (clearAfter >= 0 && pops == clearAfter) break;
            enable = ($urandom_range(0, 99) < enPct);
            ready  = ($urandom_range(0, 99) < readyPct);
            if (pops == stallBeat && stall < 5) begin
                ready = 1'b0;
                stall++;
            end
            #1;
            if (enable) begin
                checkOutput("valid", {63'd0, valid}, 64'd1);
                checkOutput("addr", {32'd0, addr}, {32'd0, eAddr[0]});
                checkOutput("strb", {60'd0, strb}, {60'd0, eStrb[0]});
                checkOutput("dimLast", {61'd0, dim_last}, {61'd0, eLast[0]});
                if (ready && valid) begin
                    void'(eAddr.pop_front());
                    void'(eStrb.pop_front());
                    void'(eLast.pop_front());
                    pops++;
                end
            end else begin
                checkOutput("validFrozen", {63'd0, valid}, 64'd0);
            end
            @(negedge clk);
            cyc++;
        end

        if (clearAfter >= 0 && eAddr.size() > 0 && pops == clearAfter) begin
            enable = 1'b1;
            ready  = 1'b0;
            clear  = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            #1;
            checkOutput("clrValid", {63'd0, valid}, 64'd0);
            checkOutput("clrBusy", {63'd0, busy}, 64'd0);
            checkOutput("clrDone", {63'd0, done}, 64'd0);
            checkOutput("clrAddr", {32'd0, addr}, 64'd0);
            @(negedge clk);
            #1;
            checkOutput("clrNoDone", {63'd0, done}, 64'd0);
            checkOutput("clrIdle", {63'd0, busy}, 64'd0);
            return;
        end

        checkOutput("noTimeout", {63'd0, (eAddr.size() > 0)}, 64'd0);
        checkOutput("beatCount", 64'(pops), 64'(total));
        enable = 1'b1;
        ready  = 1'b0;
        #1;
        checkOutput("donePulse", {63'd0, done}, 64'd1);
        checkOutput("doneBusy", {63'd0, busy}, 64'd0);
        checkOutput("doneValid", {63'd0, valid}, 64'd0);
        @(negedge clk);
        #1;
        checkOutput("doneOnce", {63'd0, done}, 64'd0);
        checkOutput("idleBusy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        test_mode = 1'b0;
        enable    = 1'b1;
        clear     = 1'b0;
        start     = 1'b0;
        ready     = 1'b0;
        base_addr = 32'h1234_5678;
        len_m1    = '1;
        stride    = '1;
        #12;
        checkOutput("rstValid", {63'd0, valid}, 64'd0);
        checkOutput("rstAddr", {32'd0, addr}, 64'd0);
        checkOutput("rstStrb", {60'd0, strb}, 64'd0);
        checkOutput("rstDimLast", {61'd0, dim_last}, 64'd0);
        checkOutput("rstBusyDone", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("postRstValid", {63'd0, valid}, 64'd0);

        // Aligned 2D case
        applyStimulus(32'h100, 16'd3, 16'd1, 16'd0, 32'h40, 32'h0, 100, 100, -1, -1);
        // Misaligned line
        applyStimulus(32'h102, 16'd1, 16'd0, 16'd0, 32'h0, 32'h0, 100, 100, -1, -1);
        // Misaligned single-word line gives two beats
        applyStimulus(32'h207, 16'd0, 16'd1, 16'd0, 32'h21, 32'h0, 100, 100, -1, -1);
        // Negative stride
        applyStimulus(32'h200, 16'd0, 16'd2, 16'd0, 32'hFFFF_FFF0, 32'h0, 100, 100, -1, -1);
        // Backpressure on beat 2
        applyStimulus(32'h100, 16'd3, 16'd1, 16'd0, 32'h40, 32'h0, 100, 100, 1, -1);
        // Clear after beat 3, then restart from beat 1
        applyStimulus(32'h100, 16'd3, 16'd1, 16'd0, 32'h40, 32'h0, 100, 100, -1, 3);
        applyStimulus(32'h100, 16'd3, 16'd1, 16'd0, 32'h40, 32'h0, 100, 100, -1, -1);
        // Degenerate single beat
        applyStimulus(32'h300, 16'd0, 16'd0, 16'd0, 32'h10, 32'h20, 100, 100, -1, -1);
        // Freeze via enable
        applyStimulus(32'h400, 16'd2, 16'd1, 16'd1, 32'h30, 32'h100, 100, 60, -1, -1);

        // Randomised transfers with random ready/enable and all three dimensions
        for (int t = 0; t < 25; t++) begin
            applyStimulus($urandom(), 16'($urandom_range(0, 5)), 16'($urandom_range(0, 3)),
                          16'($urandom_range(0, 2)), 32'($urandom_range(0, 511)) - 32'd256,
                          32'($urandom_range(0, 4095)) - 32'd2048, 60, 85, $urandom_range(0, 3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_addressgen_nd.md
Name: hwpe_stream_addressgen_nd

Overview:
- Parametrised N-dimensional successor of the streamer address generator.
- Emits a stream of word-aligned addresses with byte strobes over up to NB_DIMS nested loops, using a valid/ready handshake instead of enable-per-cycle stepping.
- Configuration is snapshotted at start. Each innermost line is independently realigned: one extra beat is added when the line start is misaligned.
- Sits between the streamer control registers and the TCDM request path of a source/sink streamer.

Parameters:
- NB_DIMS, 3, number of loop dimensions (1..4); dim 0 is innermost.
- STEP, 4, bytes per word; power of two, at least 2.
- CNT, 16, counter width per dimension.
- ADDR_W, 32, address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_mode_i  in  1  unused functionally; present for uniformity
- enable_i  in  1  local enable; 0 freezes all state
- clear_i  in  1  synchronous clear to IDLE
- start_i  in  1  start a transfer (honoured in IDLE only)
- base_addr_i  in  ADDR_W  byte base address
- len_m1_i  in  NB_DIMS*CNT  per-dimension length minus 1; dim 0 is counted in words
- stride_i  in  NB_DIMS*ADDR_W  signed byte stride per dimension; the dim 0 slice is ignored (dim 0 step is fixed at STEP)
- addr_o  out  ADDR_W  word-aligned address; low log2(STEP) bits are 0
- strb_o  out  STEP  byte strobe
- dim_last_o  out  NB_DIMS  bit d=1 when this beat closes dimension d
- addr_valid_o  out  1  address valid
- addr_ready_i  in  1  consumer ready
- busy_o  out  1  high in RUN
- done_o  out  1  one-cycle pulse after the final beat

Behaviour:
- Reset and clear:
  - Async reset: state=IDLE; all counters and offsets 0; config registers 0.
  - All outputs are 0 after reset.
  - clear_i (synchronous, highest priority after reset) gives the same values.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start_i & enable_i.
    - base_addr_i, len_m1_i and stride_i are registered in that cycle; later input changes have no effect until the next start.
    - First addr_valid_o appears in the next cycle (latency 1).
  - RUN -> DONE on the handshake of the beat where all dim_last_o bits are 1.
  - DONE -> IDLE unconditionally after one cycle; done_o=1 only during DONE.
  - start_i outside IDLE is ignored.
- Handshake:
  - addr_valid_o = (state==RUN) & enable_i.
  - A beat transfers when addr_valid_o & addr_ready_i.
  - While valid and not ready, addr_o, strb_o and dim_last_o are held stable.
  - enable_i=0 freezes every register; this is the only sanctioned case of valid dropping without a transfer.
- Address composition:
  - addr_o = (base + off_line + 4-free word offset) with the low log2(STEP) bits cleared, where off_line = sum over d>=1 of cnt_d*stride_d.
  - off_line is maintained incrementally, never with multipliers: on wrap of dim d, its partial offset returns to 0 and dim d+1 adds stride_{d+1}.
  - Strides are sign-extended.
  - All arithmetic is modulo 2^ADDR_W.
- Per-line misalignment:
  - o = line start byte address [log2(STEP)-1:0], sampled when word counter = 0.
  - Beats per line: len0+1 if o==0, otherwise len0+2.
  - First beat strb = ones<<o.
  - Last beat, only when o!=0: strb = ~(ones<<o).
  - Other beats: all ones.
  - A single-beat aligned line has all ones.
  - A misaligned line with len0=0 has two beats: ones<<o, then ~(ones<<o).
- dim_last_o:
  - dim_last_o[0] = last beat of line.
  - dim_last_o[d] = dim_last_o[d-1] & (cnt_d==len_m1_d).
- Counter width: no wrap beyond len_m1 occurs; len_m1=0 yields a single iteration of that dimension.

Test Plan:
- Aligned 2D case: base=0x100, len_m1={3,1}, stride1=0x40, ready=1 -> 8 beats at 0x100,104,108,10C,140,144,148,14C.
  - All strb=0xF.
  - dim_last_o[0] on beats 4 and 8; [1] on beat 8.
  - done_o pulses one cycle after beat 8.
- Misaligned line: base=0x102, len_m1={1,0} -> 3 beats at 0x100,0x104,0x108 with strb 0xC,0xF,0x3.
- Negative stride: base=0x200, len_m1={0,2}, stride1=-0x10 -> addresses 0x200,0x1F0,0x1E0.
- Backpressure: addr_ready_i held low 5 cycles on beat 2 -> addr_o/strb_o stable; no beat lost or duplicated; total count unchanged.
- Clear mid-operation: assert clear_i after beat 3 of 8 -> next cycle IDLE, addr_valid_o=0, busy_o=0, no done_o. A new start restarts from beat 1.
- Degenerate and freeze:
  - All len_m1=0, base aligned -> exactly 1 beat, dim_last_o all ones, then done_o.
  - enable_i=0 during RUN -> valid low and state frozen; resumes at the same beat when re-enabled.
